seq_alu_16: RTL

- Multi-cycle 16-bit ALU directly downstream of the 16-bit cache registers; consumes their data_out words as operands A and B.
- Add, subtract, logic and NOT complete in one cycle. Multiply (shift-add) and logical shift right (one bit per cycle) are iterative.
- One-cycle done pulse drives the storage_activator of the result cache register; result and flags are held stable afterwards.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/seq_alu_16_if.sv | 25 ++
 rtl/seq_alu_16_comb_core.sv | 44 ++++
 rtl/seq_alu_16.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential 16-bit ALU.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOTA = 3'd5,
    OP_MUL  = 3'd6,
    OP_SHR  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_16_if.sv
// Operand/request and result/flag bundle between the cache registers and the ALU.
interface seq_alu_16_if #(parameter int WIDTH = 16);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       opcode;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             overflow;

  modport master (
    output op_a, op_b, opcode, start,
    input  busy, done, result, carry, zero, overflow
  );

  modport slave (
    input  op_a, op_b, opcode, start,
    output busy, done, result, carry, zero, overflow
  );

endinterface

// File: rtl/seq_alu_16_comb_core.sv
// Single-cycle ALU operations (ADD..NOTA); result, carry/borrow and signed overflow.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  opcode_e          i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH:0] w_wide;

  // Operation select; the extra MSB of w_wide carries out the carry/borrow.
  always_comb begin
    w_wide     = '0;
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        w_wide     = {1'b0, i_a} + {1'b0, i_b};
        o_result   = w_wide[WIDTH-1:0];
        o_carry    = w_wide[WIDTH];
        o_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_wide[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_wide     = {1'b0, i_a} - {1'b0, i_b};
        o_result   = w_wide[WIDTH-1:0];
        o_carry    = w_wide[WIDTH];
        o_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_wide[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOTA: o_result = ~i_a;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu_16.sv
// Multi-cycle 16-bit ALU: single-cycle ops via alu_comb_core, iterative shift-add MUL and bit-serial SHR.
module seq_alu_16
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input logic         CLK,
  input logic         RST_N,
  seq_alu_16_if.slave bus
);

  localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  opcode_e            r_op;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_zero;
  logic               r_overflow;

  opcode_e            w_opcode;
  logic [SHW-1:0]     w_shamt;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_shr_val;
  logic [WIDTH-1:0]   w_core_result;
  logic               w_core_carry;
  logic               w_core_overflow;

  assign w_opcode  = opcode_e'(bus.opcode);
  assign w_shamt   = bus.op_b[SHW-1:0];
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_shr_val = {1'b0, r_shift[WIDTH-1:1]};

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_opcode   (w_opcode),
    .i_a        (bus.op_a),
    .i_b        (bus.op_b),
    .o_result   (w_core_result),
    .o_carry    (w_core_carry),
    .o_overflow (w_core_overflow)
  );

  // State register with busy/done registered alongside so they track the state exactly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic; the last EXEC iteration is the one that sees a count of one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!bus.start) begin
          w_state_nxt = ST_IDLE;
        end else if (w_opcode == OP_MUL) begin
          w_state_nxt = ST_EXEC;
        end else if ((w_opcode == OP_SHR) && (w_shamt != '0)) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_EXEC: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state, captured by the state register.
  always_comb begin
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Operand latches, iteration datapath and result/flag registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_op       <= OP_ADD;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_shift    <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op     <= w_opcode;
            r_mcand  <= {{WIDTH{1'b0}}, bus.op_a};
            r_mplier <= bus.op_b;
            r_acc    <= '0;
            r_shift  <= bus.op_a;
            case (w_opcode)
              OP_MUL: r_cnt <= CNT_MUL;
              OP_SHR: begin
                if (w_shamt != '0) begin
                  r_cnt <= {1'b0, w_shamt};
                end else begin
                  r_result   <= bus.op_a;
                  r_carry    <= 1'b0;
                  r_overflow <= 1'b0;
                  r_zero     <= (bus.op_a == '0);
                end
              end
              default: begin
                r_result   <= w_core_result;
                r_carry    <= w_core_carry;
                r_overflow <= w_core_overflow;
                r_zero     <= (w_core_result == '0);
              end
            endcase
          end
        end
        ST_EXEC: begin
          r_cnt <= r_cnt - CNT_ONE;
          case (r_op)
            OP_MUL: begin
              r_acc    <= w_acc_nxt;
              r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
              r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
              if (r_cnt == CNT_ONE) begin
                r_result   <= w_acc_nxt[WIDTH-1:0];
                r_carry    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                r_overflow <= 1'b0;
                r_zero     <= (w_acc_nxt[WIDTH-1:0] == '0);
              end
            end
            OP_SHR: begin
              r_shift <= w_shr_val;
              if (r_cnt == CNT_ONE) begin
                r_result   <= w_shr_val;
                r_carry    <= r_shift[0];
                r_overflow <= 1'b0;
                r_zero     <= (w_shr_val == '0);
              end
            end
            default: r_shift <= r_shift;
          endcase
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.carry    = r_carry;
  assign bus.zero     = r_zero;
  assign bus.overflow = r_overflow;

endmodule
